la_ioring_ctrl: RTL



---
 rtl/la_ioring_ctrl.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/la_ioring_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : la_ioring_ctrl
// Brief    : Core-side IO ring controller: power-up isolation sequencing,
//            serial configuration shift/load and ring readback.
// Revision : 1.0 - initial release
// ============================================================================
module la_ioring_ctrl #(
  parameter int RINGW  = 8,
  parameter int CFGW   = 32,
  parameter int PWRDLY = 256,
  parameter int DIV    = 4
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             sleep,
  input  logic [CFGW-1:0]  cfg,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  output logic [CFGW-1:0]  rdata,
  output logic             done,
  output logic             iso,
  input  logic             ring_in,
  output logic [RINGW-1:0] ioring
);

  localparam int PW_W = $clog2(PWRDLY + 1);
  localparam int DV_W = $clog2(2 * DIV);
  localparam int BI_W = (CFGW > 1) ? $clog2(CFGW) : 1;

  localparam logic [PW_W-1:0] C_PWR_LAST = PW_W'(PWRDLY);
  localparam logic [DV_W-1:0] C_DIV_HALF = DV_W'(DIV - 1);
  localparam logic [DV_W-1:0] C_DIV_END  = DV_W'(2 * DIV - 1);
  localparam logic [BI_W-1:0] C_BIT_LAST = BI_W'(CFGW - 1);

  localparam logic [2:0] S_PWRWAIT = 3'd0;
  localparam logic [2:0] S_IDLE    = 3'd1;
  localparam logic [2:0] S_SLEEP   = 3'd2;
  localparam logic [2:0] S_SHIFT   = 3'd3;
  localparam logic [2:0] S_LOAD    = 3'd4;

  logic [2:0]      state_q,  state_d;
  logic [PW_W-1:0] pwrcnt_q, pwrcnt_d;
  logic [DV_W-1:0] divcnt_q, divcnt_d;
  logic [BI_W-1:0] bitcnt_q, bitcnt_d;
  logic [CFGW-1:0] sreg_q,   sreg_d;
  logic [CFGW-1:0] rdata_q,  rdata_d;
  logic            iso_q,    iso_d;
  logic            rclk_q,   rclk_d;
  logic            rdin_q,   rdin_d;
  logic            rload_q,  rload_d;
  logic            ready_q,  ready_d;
  logic            done_q,   done_d;

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q  <= S_PWRWAIT;
      pwrcnt_q <= '0;
      divcnt_q <= '0;
      bitcnt_q <= '0;
      sreg_q   <= '0;
      rdata_q  <= '0;
      iso_q    <= 1'b1;
      rclk_q   <= 1'b0;
      rdin_q   <= 1'b0;
      rload_q  <= 1'b0;
      ready_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pwrcnt_q <= pwrcnt_d;
      divcnt_q <= divcnt_d;
      bitcnt_q <= bitcnt_d;
      sreg_q   <= sreg_d;
      rdata_q  <= rdata_d;
      iso_q    <= iso_d;
      rclk_q   <= rclk_d;
      rdin_q   <= rdin_d;
      rload_q  <= rload_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pwrcnt_d = pwrcnt_q;
    divcnt_d = divcnt_q;
    bitcnt_d = bitcnt_q;
    sreg_d   = sreg_q;
    rdata_d  = rdata_q;
    case (state_q)
      S_PWRWAIT: begin
        if (pwrcnt_q == C_PWR_LAST) begin
          state_d  = S_IDLE;
          pwrcnt_d = '0;
        end else begin
          pwrcnt_d = pwrcnt_q + 1'b1;
        end
      end
      S_IDLE: begin
        // A pending config takes priority over a sleep request.
        if (cfg_valid && ready_q) begin
          state_d  = S_SHIFT;
          sreg_d   = cfg;
          divcnt_d = '0;
          bitcnt_d = '0;
        end else if (sleep) begin
          state_d = S_SLEEP;
        end
      end
      S_SLEEP: begin
        if (!sleep) begin
          state_d  = S_PWRWAIT;
          pwrcnt_d = '0;
        end
      end
      S_SHIFT: begin
        // Return data is captured on the cycle the ring clock rises.
        if (divcnt_q == C_DIV_HALF) begin
          rdata_d = (rdata_q >> 1) | (CFGW'(ring_in) << (CFGW - 1));
        end
        if (divcnt_q == C_DIV_END) begin
          divcnt_d = '0;
          sreg_d   = sreg_q >> 1;
          if (bitcnt_q == C_BIT_LAST) begin
            state_d  = S_LOAD;
            bitcnt_d = '0;
          end else begin
            bitcnt_d = bitcnt_q + 1'b1;
          end
        end else begin
          divcnt_d = divcnt_q + 1'b1;
        end
      end
      S_LOAD: begin
        if (divcnt_q == C_DIV_HALF) begin
          state_d  = S_IDLE;
          divcnt_d = '0;
        end else begin
          divcnt_d = divcnt_q + 1'b1;
        end
      end
      default: begin
        state_d  = S_PWRWAIT;
        pwrcnt_d = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the pins are registered
  // yet line up with the state they belong to.
  always_comb begin
    iso_d   = (state_d == S_PWRWAIT) || (state_d == S_SLEEP);
    ready_d = (state_d == S_IDLE);
    rclk_d  = (state_d == S_SHIFT) && (divcnt_d > C_DIV_HALF);
    rdin_d  = (state_d == S_SHIFT) && sreg_d[0];
    rload_d = (state_d == S_LOAD);
    done_d  = (state_q == S_LOAD) && (state_d == S_IDLE);
  end

  assign cfg_ready = ready_q;
  assign rdata     = rdata_q;
  assign done      = done_q;
  assign iso       = iso_q;
  assign ioring    = {{(RINGW - 4){1'b0}}, rload_q, rdin_q, rclk_q, iso_q};

endmodule
`default_nettype wire
